// File: rtl/wr_ctrl_mport_pkg.sv
// Shared types and AXI constants for the multi-port write controller.
package wr_ctrl_mport_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
    localparam logic [2:0] AXI_AWSIZE_DEFAULT = 3'b110;

    // Width of a port index; a single port still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_ctrl_mport_rr_arbiter.sv
// Round-robin arbiter: priority starts at the port after the last winner.
module rr_arbiter
    import wr_ctrl_mport_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               i_req,
    input  logic                               i_advance,
    output logic [NUM_PORTS-1:0]               o_grant,
    output logic [idx_width(NUM_PORTS)-1:0]    o_grant_idx
);

    localparam int IW = idx_width(NUM_PORTS);

    logic [IW-1:0]        r_ptr;
    logic [NUM_PORTS-1:0] w_grant;
    logic [IW-1:0]        w_idx;
    logic                 w_found;

    // First pass covers ports at or above the pointer, second pass wraps.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_found && i_req[p] && (p >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_idx      = IW'(p);
                w_grant[p] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_found && i_req[p] && (p < int'(r_ptr))) begin
                w_found    = 1'b1;
                w_idx      = IW'(p);
                w_grant[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_idx == IW'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/wr_ctrl_mport.sv
// Multi-port AXI write controller: arbitrates client bursts onto one AXI
// write channel with a single transaction outstanding.
module wr_ctrl_mport
    import wr_ctrl_mport_pkg::*;
#(
    parameter int         CTRL_ADDR_WIDTH = 28,
    parameter int         MEM_DQ_WIDTH    = 16,
    parameter int         NUM_PORTS       = 2,
    parameter logic [2:0] AWSIZE          = AXI_AWSIZE_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  wr_req,
    input  logic [NUM_PORTS*CTRL_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_PORTS*4-1:0]                wr_len,
    output logic [NUM_PORTS-1:0]                  wr_grant,
    input  logic [NUM_PORTS*MEM_DQ_WIDTH*8-1:0]   wr_data,
    input  logic [NUM_PORTS-1:0]                  wr_data_valid,
    output logic [NUM_PORTS-1:0]                  wr_data_ready,
    output logic [NUM_PORTS-1:0]                  wr_done,
    output logic [NUM_PORTS-1:0]                  wr_err,
    output logic [CTRL_ADDR_WIDTH-1:0]            axi_awaddr,
    output logic [3:0]                            axi_awid,
    output logic [3:0]                            axi_awlen,
    output logic [2:0]                            axi_awsize,
    output logic [1:0]                            axi_awburst,
    output logic                                  axi_awvalid,
    input  logic                                  axi_awready,
    output logic [MEM_DQ_WIDTH*8-1:0]             axi_wdata,
    output logic [MEM_DQ_WIDTH-1:0]               axi_wstrb,
    output logic                                  axi_wlast,
    output logic                                  axi_wvalid,
    input  logic                                  axi_wready,
    input  logic [3:0]                            axi_bid,
    input  logic [1:0]                            axi_bresp,
    input  logic                                  axi_bvalid,
    output logic                                  axi_bready,
    output logic                                  busy,
    output logic [1:0]                            state
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam int DW = MEM_DQ_WIDTH * 8;

    wr_state_t                r_state;
    wr_state_t                w_next;
    logic [IW-1:0]            r_port;
    logic [CTRL_ADDR_WIDTH-1:0] r_addr;
    logic [3:0]               r_len;
    logic [3:0]               r_beat;
    logic [NUM_PORTS-1:0]     r_done;
    logic [NUM_PORTS-1:0]     r_err;

    logic [NUM_PORTS-1:0]     w_arb_grant;
    logic [IW-1:0]            w_arb_idx;
    logic                     w_grant_fire;
    logic                     w_sel_valid;
    logic [DW-1:0]            w_sel_data;
    logic [NUM_PORTS-1:0]     w_port_oh;
    logic [CTRL_ADDR_WIDTH-1:0] w_req_addr;
    logic [3:0]               w_req_len;
    logic                     w_beat_hs;
    logic                     w_b_hs;
    logic                     w_b_bad;

    // No grant during reset or in the cycle a completion pulse is showing.
    assign w_grant_fire = rst_n && (r_state == ST_IDLE) && (r_done == '0) && (|wr_req);

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (wr_req),
        .i_advance   (w_grant_fire),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_port_oh   = '0;
        w_req_addr  = '0;
        w_req_len   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_port == IW'(p)) begin
                w_sel_valid  = wr_data_valid[p];
                w_sel_data   = wr_data[p*DW +: DW];
                w_port_oh[p] = 1'b1;
            end
            if (w_arb_idx == IW'(p)) begin
                w_req_addr = wr_addr[p*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
                w_req_len  = wr_len[p*4 +: 4];
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        wr_grant      = '0;
        axi_awvalid   = 1'b0;
        axi_wvalid    = 1'b0;
        axi_wlast     = 1'b0;
        wr_data_ready = '0;
        axi_bready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_fire) begin
                    wr_grant = w_arb_grant;
                    w_next   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                axi_awvalid = 1'b1;
                if (axi_awready) w_next = ST_DATA;
            end
            ST_DATA: begin
                axi_wvalid    = w_sel_valid;
                axi_wlast     = (r_beat == r_len);
                wr_data_ready = w_port_oh & {NUM_PORTS{axi_wready}};
                if (w_sel_valid && axi_wready && (r_beat == r_len)) w_next = ST_RESP;
            end
            ST_RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_beat_hs = (r_state == ST_DATA) && w_sel_valid && axi_wready;
    assign w_b_hs    = (r_state == ST_RESP) && axi_bvalid;
    assign w_b_bad   = (axi_bresp != AXI_RESP_OKAY) || (axi_bid != axi_awid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_port  <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            r_err   <= '0;
            if (w_grant_fire) begin
                r_port <= w_arb_idx;
                r_addr <= w_req_addr;
                r_len  <= w_req_len;
            end
            if (w_beat_hs) begin
                r_beat <= axi_wlast ? 4'd0 : r_beat + 4'd1;
            end
            if (w_b_hs) begin
                r_done <= w_port_oh;
                if (w_b_bad) r_err <= w_port_oh;
            end
        end
    end

    assign axi_awaddr  = r_addr;
    assign axi_awid    = 4'(r_port);
    assign axi_awlen   = r_len;
    assign axi_awsize  = AWSIZE;
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wdata   = w_sel_data;
    assign axi_wstrb   = '1;
    assign wr_done     = r_done;
    assign wr_err      = r_err;
    assign busy        = (r_state != ST_IDLE);
    assign state       = r_state;

endmodule

// File: tb/tb_wr_ctrl_mport.sv
// Randomized scoreboard bench for wr_ctrl_mport with an AXI slave model.
module tb_wr_ctrl_mport;

    localparam int NP = 2;
    localparam int CW = 28;
    localparam int DQ = 16;
    localparam int DW = DQ * 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     wr_req;
    logic [NP*CW-1:0]  wr_addr;
    logic [NP*4-1:0]   wr_len;
    logic [NP-1:0]     wr_grant;
    logic [NP*DW-1:0]  wr_data;
    logic [NP-1:0]     wr_data_valid;
    logic [NP-1:0]     wr_data_ready;
    logic [NP-1:0]     wr_done;
    logic [NP-1:0]     wr_err;
    logic [CW-1:0]     axi_awaddr;
    logic [3:0]        axi_awid;
    logic [3:0]        axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DW-1:0]     axi_wdata;
    logic [DQ-1:0]     axi_wstrb;
    logic              axi_wlast;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [3:0]        axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic              busy;
    logic [1:0]        state;

    wr_ctrl_mport #(
        .CTRL_ADDR_WIDTH (CW),
        .MEM_DQ_WIDTH    (DQ),
        .NUM_PORTS       (NP),
        .AWSIZE          (3'b110)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_grant      (wr_grant),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_done       (wr_done),
        .wr_err        (wr_err),
        .axi_awaddr    (axi_awaddr),
        .axi_awid      (axi_awid),
        .axi_awlen     (axi_awlen),
        .axi_awsize    (axi_awsize),
        .axi_awburst   (axi_awburst),
        .axi_awvalid   (axi_awvalid),
        .axi_awready   (axi_awready),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wlast     (axi_wlast),
        .axi_wvalid    (axi_wvalid),
        .axi_wready    (axi_wready),
        .axi_bid       (axi_bid),
        .axi_bresp     (axi_bresp),
        .axi_bvalid    (axi_bvalid),
        .axi_bready    (axi_bready),
        .busy          (busy),
        .state         (state)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            n_vec = 0;
    int            n_err = 0;
    logic [35:0]   exp_aw_q[$];
    logic [DW:0]   exp_w_q[$];
    logic [3:0]    cur_id;
    bit            b_owed;
    bit            pend_done;
    logic [NP-1:0] exp_done;
    logic [NP-1:0] exp_err;
    int            model_ptr;
    int            aw_mode;
    int            w_mode;
    int            b_mode;
    int            last_wait;
    logic [DW-1:0] rd[16];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, state, 2'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_awvalid"}, axi_awvalid, 1'b0);
        chk({tag, "_wvalid"}, axi_wvalid, 1'b0);
        chk({tag, "_wlast"}, axi_wlast, 1'b0);
        chk({tag, "_bready"}, axi_bready, 1'b0);
        chk({tag, "_grant"}, wr_grant, '0);
        chk({tag, "_done"}, wr_done, '0);
        chk({tag, "_err"}, wr_err, '0);
        chk({tag, "_dready"}, wr_data_ready, '0);
        chk({tag, "_awaddr"}, axi_awaddr, '0);
        chk({tag, "_awid"}, axi_awid, '0);
        chk({tag, "_awlen"}, axi_awlen, '0);
    endtask

    // Negedge monitor: reference round-robin model plus AW/W/B scoreboards.
    task automatic monitor_loop();
        logic [35:0]   e_aw;
        logic [DW:0]   e_w;
        logic [NP-1:0] exp_g;
        int            gidx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_owed    = 0;
                pend_done = 0;
                model_ptr = 0;
                continue;
            end
            if (pend_done) begin
                chk("done_vec", wr_done, exp_done);
                chk("err_vec", wr_err, exp_err);
                pend_done = 0;
            end else if (wr_done != '0 || wr_err != '0) begin
                chk("spurious_done", {wr_done, wr_err}, '0);
            end
            if (wr_grant != '0) begin
                exp_g = '0;
                gidx  = -1;
                for (int k = 0; k < NP; k++) begin
                    int q;
                    q = (model_ptr + k) % NP;
                    if (gidx < 0 && wr_req[q]) gidx = q;
                end
                if (gidx >= 0) begin
                    exp_g[gidx] = 1'b1;
                    model_ptr   = (gidx + 1) % NP;
                end
                chk("grant", wr_grant, exp_g);
                chk("grant_in_done_cycle", wr_done, '0);
            end
            if (axi_awvalid && axi_awready) begin
                if (exp_aw_q.size() == 0) begin
                    chk("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    e_aw   = exp_aw_q.pop_front();
                    cur_id = e_aw[7:4];
                    chk("aw", {axi_awaddr, axi_awid, axi_awlen}, e_aw);
                    chk("aw_const", {axi_awsize, axi_awburst}, {3'b110, 2'b01});
                end
            end
            if (axi_wvalid && axi_wready) begin
                if (exp_w_q.size() == 0) begin
                    chk("w_unexpected", 1'b1, 1'b0);
                end else begin
                    e_w = exp_w_q.pop_front();
                    chk("w_beat", {axi_wlast, axi_wdata}, e_w);
                    chk("wstrb", axi_wstrb, {DQ{1'b1}});
                    if (e_w[DW]) b_owed = 1;
                end
            end
            if (axi_bvalid && axi_bready) begin
                pend_done = 1;
                b_owed    = 0;
                exp_done  = NP'(1) << cur_id;
                exp_err   = ((axi_bresp != 2'b00) || (axi_bid != cur_id)) ? (NP'(1) << cur_id) : '0;
            end
        end
    endtask

    // AXI slave: ready patterns and a B response some cycles after the last beat.
    task automatic slave_loop();
        int r;
        forever begin
            step();
            if (!rst_n) begin
                axi_awready = 1'b0;
                axi_wready  = 1'b0;
                axi_bvalid  = 1'b0;
                axi_bresp   = 2'b00;
                axi_bid     = 4'd0;
                continue;
            end
            axi_awready = (aw_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            case (w_mode)
                1:       axi_wready = 1'b1;
                2:       axi_wready = ~axi_wready;
                default: axi_wready = 1'($urandom_range(0, 1));
            endcase
            if (axi_bvalid && !b_owed) begin
                axi_bvalid = 1'b0;
            end else if (b_owed && !axi_bvalid && $urandom_range(0, 1) == 1) begin
                axi_bvalid = 1'b1;
                axi_bid    = cur_id;
                axi_bresp  = 2'b00;
                if (b_mode == 2) axi_bresp = 2'b10;
                if (b_mode == 0) begin
                    r = $urandom_range(0, 7);
                    if (r == 0) axi_bresp = 2'b10;
                    if (r == 1) axi_bresp = 2'b11;
                    if (r == 2) axi_bid = cur_id ^ 4'h2;
                end
            end
        end
    endtask

    // One client: len_sel < 0 picks a random length biased toward 0 and 15.
    task automatic run_client(input int p, input int n, input int len_sel, input int gap_max,
                              input bit fix_addr, input logic [CW-1:0] faddr);
        logic [CW-1:0] a;
        logic [3:0]    l;
        logic [DW-1:0] d[16];
        int            t;
        int            r;
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, gap_max)) step();
            if (len_sel >= 0) begin
                l = 4'(len_sel);
            end else begin
                r = $urandom_range(0, 5);
                l = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            end
            a = fix_addr ? faddr : CW'($urandom);
            for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
            wr_addr[p*CW +: CW] = a;
            wr_len[p*4 +: 4]    = l;
            wr_req[p]           = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!wr_grant[p] && t < 3000);
            last_wait = t;
            chk("grant_wait", (t >= 3000), 1'b0);
            if (t >= 3000) begin
                wr_req[p] = 1'b0;
                return;
            end
            exp_aw_q.push_back({a, 4'(p), l});
            for (int i = 0; i <= int'(l); i++) exp_w_q.push_back({(i == int'(l)), d[i]});
            step();
            wr_req[p] = 1'b0;
            for (int i = 0; i <= int'(l); i++) begin
                repeat ($urandom_range(0, gap_max)) step();
                wr_data_valid[p]     = 1'b1;
                wr_data[p*DW +: DW]  = d[i];
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!wr_data_ready[p] && t < 3000);
                chk("data_wait", (t >= 3000), 1'b0);
                step();
                wr_data_valid[p] = 1'b0;
                if (t >= 3000) return;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || pend_done || exp_w_q.size() != 0) && t < 3000) begin
            step();
            t++;
        end
        chk("idle_timeout", (t >= 3000), 1'b0);
        step();
        step();
    endtask

    initial begin
        int t;
        int beats;
        rst_n         = 1'b0;
        wr_req        = '0;
        wr_addr       = '0;
        wr_len        = '0;
        wr_data       = '0;
        wr_data_valid = '0;
        axi_awready   = 1'b0;
        axi_wready    = 1'b0;
        axi_bid       = 4'd0;
        axi_bresp     = 2'b00;
        axi_bvalid    = 1'b0;
        aw_mode       = 1;
        w_mode        = 1;
        b_mode        = 1;
        b_owed        = 0;
        pend_done     = 0;
        model_ptr     = 0;
        cur_id        = 4'd0;
        fork
            monitor_loop();
            slave_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single len=3 burst to 0x100 with both readies held high.
        run_client(0, 1, 3, 0, 1'b1, 28'h100);
        wait_idle();

        // Both ports back-to-back single beats: grants must alternate.
        fork
            run_client(0, 4, 0, 0, 1'b0, '0);
            run_client(1, 4, 0, 0, 1'b0, '0);
        join
        wait_idle();

        // len=7 with wready toggling every cycle.
        w_mode = 2;
        run_client(1, 1, 7, 0, 1'b0, '0);
        wait_idle();

        // SLVERR on port 1, then a normal burst must still go through.
        w_mode = 1;
        b_mode = 2;
        run_client(1, 1, 2, 0, 1'b0, '0);
        wait_idle();
        b_mode = 1;
        run_client(0, 1, 1, 0, 1'b0, '0);
        wait_idle();

        // Random traffic from both ports against a random slave.
        aw_mode = 0;
        w_mode  = 0;
        b_mode  = 0;
        fork
            run_client(0, 15, -1, 3, 1'b0, '0);
            run_client(1, 15, -1, 3, 1'b0, '0);
        join
        wait_idle();

        // Reset while beat 3 of a len=15 burst is on the bus.
        aw_mode = 1;
        w_mode  = 1;
        b_mode  = 1;
        for (int i = 0; i < 16; i++) rd[i] = {$urandom, $urandom, $urandom, $urandom};
        wr_addr[CW-1:0] = 28'h0ABC0;
        wr_len[3:0]     = 4'd15;
        wr_req[0]       = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_grant[0] && t < 50);
        chk("rst_burst_grant", wr_grant[0], 1'b1);
        exp_aw_q.push_back({28'h0ABC0, 4'd0, 4'd15});
        for (int i = 0; i < 16; i++) exp_w_q.push_back({(i == 15), rd[i]});
        step();
        wr_req[0]        = 1'b0;
        wr_data_valid[0] = 1'b1;
        beats = 0;
        t = 0;
        forever begin
            wr_data[DW-1:0] = rd[beats];
            @(negedge clk);
            t++;
            if (beats == 2 || t > 60) break;
            if (wr_data_ready[0]) beats++;
            step();
        end
        chk("rst_beat3_state", state, 2'd2);
        rst_n  = 1'b0;
        wr_req = '1;
        #1;
        check_reset_outputs("midrst");
        wr_req        = '0;
        wr_data_valid = '0;
        repeat (3) @(posedge clk);
        exp_aw_q.delete();
        exp_w_q.delete();
        step();
        rst_n = 1'b1;
        run_client(0, 1, 5, 0, 1'b0, '0);
        chk("post_rst_grant_latency", last_wait, 1);
        wait_idle();

        chk("aw_queue_drained", exp_aw_q.size(), 0);
        chk("w_queue_drained", exp_w_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wr_ctrl_mport.md
WR_CTRL_MPORT -- requirements
Module: wr_ctrl_mport

Interface
REQ-001 Parameter CTRL_ADDR_WIDTH, default 28, AXI address width.
REQ-002 Parameter MEM_DQ_WIDTH, default 16; data beat = MEM_DQ_WIDTH*8 bits, strobe = MEM_DQ_WIDTH bits.
REQ-003 Parameter NUM_PORTS, default 2, legal 1..4; number of write client ports.
REQ-004 Parameter AWSIZE, default 3'b110, driven constant on axi_awsize.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low: clk and rst_n.
REQ-006 clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-007 wr_req  in  NUM_PORTS  per-port burst request, level, held until wr_grant.
REQ-008 wr_addr  in  NUM_PORTS*CTRL_ADDR_WIDTH  per-port burst address; wr_len  in  NUM_PORTS*4  per-port beats-1.
REQ-009 wr_grant  out  NUM_PORTS  one-hot 1-cycle pulse: request accepted, addr/len sampled.
REQ-010 wr_data  in  NUM_PORTS*MEM_DQ_WIDTH*8; wr_data_valid  in  NUM_PORTS; wr_data_ready  out  NUM_PORTS  per-port data handshake.
REQ-011 wr_done  out  NUM_PORTS  1-cycle pulse on B response; wr_err  out  NUM_PORTS  pulse with wr_done when bresp != OKAY.
REQ-012 axi_awaddr/awid(4)/awlen(4)/awsize(3)/awburst(2)/awvalid  out, axi_awready  in.
REQ-013 axi_wdata/wstrb/wlast/wvalid  out, axi_wready  in; axi_bid(4)/bresp(2)/bvalid  in, axi_bready  out.
REQ-014 busy  out  1  high whenever state != IDLE; state  out  2  current state for debug.

Function
REQ-015 States IDLE, ADDR, DATA, RESP; exactly one AXI transaction outstanding.
REQ-016 IDLE: if any wr_req, grant one port by round-robin starting after last granted port (reset pointer = port 0 priority), pulse wr_grant, register addr/len/port, go ADDR next cycle.
REQ-017 ADDR: axi_awvalid=1 with registered addr, awlen=len, awid=port index; on awvalid&awready go DATA.
REQ-018 axi_awburst constant 2'b01; axi_wstrb all ones.
REQ-019 DATA: axi_wvalid = wr_data_valid[port]; wr_data_ready[port] = axi_wready; other ports' ready = 0; axi_wdata muxed from granted port.
REQ-020 Beat counter (4 bit) increments on wvalid&wready; axi_wlast = 1 when counter == len; beat accepted with wlast goes RESP, counter clears.
REQ-021 wvalid SHALL not depend combinationally on wready; once asserted, wvalid/wdata held stable by the client until accepted.
REQ-022 RESP: axi_bready=1 only in RESP; on bvalid, pulse wr_done[port], wr_err[port] if bresp != 2'b00, go IDLE.
REQ-023 bid != registered awid in RESP: still complete, assert wr_err[port].
REQ-024 len = 0: single beat, wlast on first beat.
REQ-025 len = 15: 16 beats, counter reaches 15 without wrap before clearing.
REQ-026 New grant not issued in the cycle wr_done pulses; earliest next grant the cycle after return to IDLE.
REQ-027 Request dropped before grant: no transaction; all-ports-request: each port granted once per NUM_PORTS grants.

Reset
REQ-028 On rst_n low, immediately: state=IDLE, awvalid=0, wvalid path gated 0, bready=0, wr_grant/wr_done/wr_err/wr_data_ready=0, counters and awaddr/awid/awlen=0, RR pointer=0.
REQ-029 Reset mid-burst abandons transaction without completion pulse; block accepts new requests the first cycle after release.

Structure
REQ-030 Shared package: state encodings, AXI burst/resp constants (INCR, OKAY), AWSIZE default.
REQ-031 One sub-module rr_arbiter (NUM_PORTS, req vector, advance strobe, one-hot grant).

Verification
REQ-032 Port0 req addr=0x100 len=3, awready/wready always 1 -> awaddr=0x100 awid=0 awlen=3, 4 beats, wlast on beat 4, wr_done[0] one cycle after bvalid.
REQ-033 Both ports request continuously len=0 -> grants alternate 0,1,0,1; awid matches.
REQ-034 wready toggled 1,0,1,0 during len=7 burst -> exactly 8 beats, data order preserved, wlast only on 8th.
REQ-035 bresp=2'b10 on port1 burst -> wr_done[1] and wr_err[1] same cycle, next grant proceeds.
REQ-036 rst_n asserted during beat 3 of len=15 -> outputs zero same cycle, no wr_done, next request after release completes normally.
